branch_calculator: RTL and testbench

- Branch-resolution unit for the pipelined RAT CPU.
- Takes the decoded branch type from the decode/execute stage and the current C and Z flags, and produces a single taken/not-taken decision.
- The decision is registered and drives the fetch-stage PC select and the pipeline flush logic.

---
 rtl/rat_branch_pkg.sv | 39 +++
 rtl/branch_calculator.sv | 40 ++++
 tb/tb_branch_calculator.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rat_branch_pkg.sv
// Branch-type encodings and taken-condition decode shared by the RAT CPU
// decode stage and the branch-resolution unit.
package rat_branch_pkg;

  localparam int BR_TYPE_W = 4;

  localparam logic [BR_TYPE_W-1:0] BR_NONE  = 4'd0;
  localparam logic [BR_TYPE_W-1:0] BR_BRN   = 4'd1;
  localparam logic [BR_TYPE_W-1:0] BR_BREQ  = 4'd2;
  localparam logic [BR_TYPE_W-1:0] BR_BRNE  = 4'd3;
  localparam logic [BR_TYPE_W-1:0] BR_BRCS  = 4'd4;
  localparam logic [BR_TYPE_W-1:0] BR_BRCC  = 4'd5;
  localparam logic [BR_TYPE_W-1:0] BR_CALL  = 4'd6;
  localparam logic [BR_TYPE_W-1:0] BR_RET   = 4'd7;
  localparam logic [BR_TYPE_W-1:0] BR_RETID = 4'd8;
  localparam logic [BR_TYPE_W-1:0] BR_RETIE = 4'd9;

  // Reserved codes 10-15 fall to the default arm and never redirect.
  function automatic logic branch_cond(input logic [BR_TYPE_W-1:0] br_type,
                                       input logic c, input logic z);
    logic taken;
    taken = 1'b0;
    case (br_type)
      BR_NONE:  taken = 1'b0;
      BR_BRN:   taken = 1'b1;
      BR_BREQ:  taken = z;
      BR_BRNE:  taken = ~z;
      BR_BRCS:  taken = c;
      BR_BRCC:  taken = ~c;
      BR_CALL,
      BR_RET,
      BR_RETID,
      BR_RETIE: taken = 1'b1;
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_calculator.sv
// Resolves taken/not-taken from branch type and C/Z flags for PC select and flush.
// Latency: 1 cycle when REGISTER_OUTPUT=1, combinational otherwise; no backpressure.
module branch_calculator
  import rat_branch_pkg::*;
#(
  parameter bit REGISTER_OUTPUT = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 C,
  input  logic                 Z,
  input  logic [BR_TYPE_W-1:0] BRANCH_TYPE,
  output logic                 BRANCH_TAKEN
);

  logic taken_next;

  always_comb begin
    taken_next = branch_cond(BRANCH_TYPE, C, Z);
  end

  generate
    if (REGISTER_OUTPUT) begin : g_reg
      logic taken_q;

      always_ff @(posedge CLK) begin
        if (RST) taken_q <= 1'b0;
        else     taken_q <= taken_next;
      end

      assign BRANCH_TAKEN = taken_q;
    end else begin : g_comb
      // Clock and reset are intentionally unused in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = CLK ^ RST;
      assign BRANCH_TAKEN   = taken_next;
    end
  endgenerate

endmodule

// File: tb/tb_branch_calculator.sv
// Directed and random checks of branch_calculator in registered and combinational builds.
module tb_branch_calculator;

  logic       clk;
  logic       rst;
  logic       c, z;
  logic [3:0] br_type;
  logic       taken;

  logic       c2, z2, rst2;
  logic [3:0] br_type2;
  logic       taken2;

  int n_checks;
  int n_fail;

  // Bit k of entry t is the expected decision for type t with {C,Z} = k.
  logic [3:0] exp_tab [0:15];

  branch_calculator #(.REGISTER_OUTPUT(1'b1)) dut_reg (
    .CLK(clk), .RST(rst), .C(c), .Z(z),
    .BRANCH_TYPE(br_type), .BRANCH_TAKEN(taken)
  );

  branch_calculator #(.REGISTER_OUTPUT(1'b0)) dut_comb (
    .CLK(clk), .RST(rst2), .C(c2), .Z(z2),
    .BRANCH_TYPE(br_type2), .BRANCH_TAKEN(taken2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; br_type = 4'd1; c = 1'b0; z = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (taken !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %b expected 0", i, taken);
      end
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (taken !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected 1", taken);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] row;
    for (int t = 0; t < 16; t++) begin
      row = exp_tab[t];
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        br_type = 4'(t);
        {c, z}  = 2'(k);
        @(posedge clk); #1;
        n_checks++;
        if (taken !== row[k]) begin
          n_fail++;
          $display("FAIL sweep type %0d cz %0d: got %b expected %b", t, k, taken, row[k]);
        end
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk); br_type = 4'd2; c = 1'b0; z = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (taken !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_pre: got %b expected 0", taken);
    end
    @(negedge clk); z = 1'b1; #1;
    n_checks++;
    if (taken !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got %b expected 0", taken);
    end
    @(posedge clk); #1;
    n_checks++;
    if (taken !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_edge: got %b expected 1", taken);
    end
  endtask

  task automatic test_midstream_reset();
    @(negedge clk); br_type = 4'd6; c = 1'b0; z = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (taken !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_before: got %b expected 1", taken);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (taken !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_pulse: got %b expected 0", taken);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (taken !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_after: got %b expected 1", taken);
    end
  endtask

  task automatic test_comb_build();
    br_type2 = 4'd4; z2 = 1'b0; rst2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #3 c2 = i[0];
      #1;
      n_checks++;
      if (taken2 !== c2) begin
        n_fail++;
        $display("FAIL comb_track step %0d: got %b expected %b", i, taken2, c2);
      end
    end
    br_type2 = 4'd3; z2 = 1'b1; #1;
    n_checks++;
    if (taken2 !== 1'b0) begin
      n_fail++;
      $display("FAIL comb_brne: got %b expected 0", taken2);
    end
  endtask

  task automatic test_random();
    logic [3:0] row;
    logic       exp;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      br_type = 4'($urandom_range(0, 15));
      c       = 1'($urandom);
      z       = 1'($urandom);
      row     = exp_tab[br_type];
      exp     = row[{c, z}];
      @(posedge clk); #1;
      n_checks++;
      if (taken !== exp) begin
        n_fail++;
        $display("FAIL random iter %0d type %0d c %b z %b: got %b expected %b",
                 i, br_type, c, z, taken, exp);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_tab[0]  = 4'b0000;
    exp_tab[1]  = 4'b1111;
    exp_tab[2]  = 4'b1010;
    exp_tab[3]  = 4'b0101;
    exp_tab[4]  = 4'b1100;
    exp_tab[5]  = 4'b0011;
    exp_tab[6]  = 4'b1111;
    exp_tab[7]  = 4'b1111;
    exp_tab[8]  = 4'b1111;
    exp_tab[9]  = 4'b1111;
    for (int t = 10; t < 16; t++) exp_tab[t] = 4'b0000;
    c2 = 1'b0; z2 = 1'b0; rst2 = 1'b0; br_type2 = 4'd0;

    test_reset();
    test_sweep();
    test_latency();
    test_midstream_reset();
    test_comb_build();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
